// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction-fetch front end. It owns the fetch PC,
// issues imem requests and buffers returned words with their PCs in a FIFO.
module fetch_queue_unit #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic                         ihit,
    input  logic [DATA_W-1:0]            imemload,
    output logic                         imemREN,
    output logic [ADDR_W-1:0]            imemaddr,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         halt,
    input  logic                         deq_ready,
    output logic                         inst_valid,
    output logic [DATA_W-1:0]            inst,
    output logic [ADDR_W-1:0]            inst_pc,
    output logic [ADDR_W-1:0]            inst_npc,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        FLUSH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_n;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic               ren_q, ren_n;
    logic               push, pop, mem_we;

    logic [DATA_W-1:0]  mem_inst [DEPTH];
    logic [ADDR_W-1:0]  mem_pc   [DEPTH];

    // Head of queue; everything reads as zero while the queue is empty.
    always_comb begin
        inst_valid = (count_q != '0);
        inst       = '0;
        inst_pc    = '0;
        inst_npc   = '0;
        if (count_q != '0) begin
            inst     = mem_inst[rd_ptr_q];
            inst_pc  = mem_pc[rd_ptr_q];
            inst_npc = mem_pc[rd_ptr_q] + ADDR_W'(4);
        end
    end

    assign imemREN  = ren_q;
    assign imemaddr = fetch_pc_q;
    assign count    = count_q;

    // Next-state logic: queue bookkeeping, then flush/halt overrides.
    always_comb begin
        state_n    = state_q;
        fetch_pc_n = fetch_pc_q;
        rd_ptr_n   = rd_ptr_q;
        wr_ptr_n   = wr_ptr_q;
        count_n    = count_q;
        push       = 1'b0;
        pop        = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            FETCH: begin
                push = ren_q & ihit;
                pop  = inst_valid & deq_ready;
                if (push) begin
                    wr_ptr_n   = wr_ptr_q + PTR_W'(1);
                    fetch_pc_n = fetch_pc_q + ADDR_W'(4);
                end
                if (pop) begin
                    rd_ptr_n = rd_ptr_q + PTR_W'(1);
                end
                if (push && !pop) begin
                    count_n = count_q + CNT_W'(1);
                end else if (pop && !push) begin
                    count_n = count_q - CNT_W'(1);
                end
            end
            FLUSH: begin
                state_n = FETCH;
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        mem_we = push;

        // Halt beats redirect; both discard this cycle's push and pop.
        if (state_q != HALTED) begin
            if (halt) begin
                state_n    = HALTED;
                fetch_pc_n = fetch_pc_q;
                rd_ptr_n   = '0;
                wr_ptr_n   = '0;
                count_n    = '0;
                mem_we     = 1'b0;
            end else if (redirect) begin
                state_n    = FLUSH;
                fetch_pc_n = redirect_pc & ~ADDR_W'(3);
                rd_ptr_n   = '0;
                wr_ptr_n   = '0;
                count_n    = '0;
                mem_we     = 1'b0;
            end
        end

        // Request is registered so it drops to zero while reset is held.
        ren_n = (state_n == FETCH) && (count_n < CNT_W'(DEPTH));
    end

    // State, pointer, counter and request registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FETCH;
            fetch_pc_q <= PC_INIT;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ren_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            fetch_pc_q <= fetch_pc_n;
            rd_ptr_q   <= rd_ptr_n;
            wr_ptr_q   <= wr_ptr_n;
            count_q    <= count_n;
            ren_q      <= ren_n;
        end
    end

    // Queue storage; contents are only observed through count, so no reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_inst[wr_ptr_q] <= imemload;
            mem_pc[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed vector table plus hand sequences for
// reset, address wrap and mid-operation reset.
module tb_fetch_queue_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, redirect, halt, deq_ready;
    logic [31:0] imemload, redirect_pc;
    logic        imemREN, inst_valid;
    logic [31:0] imemaddr, inst, inst_pc, inst_npc;
    logic [2:0]  count;

    int n_chk = 0;
    int n_bad = 0;

    fetch_queue_unit #(.DEPTH(4), .ADDR_W(32), .DATA_W(32), .PC_INIT(32'h0)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .deq_ready(deq_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_npc(inst_npc), .count(count)
    );

    always #5 CLK = ~CLK;

    // Memory model: each word is tagged with its own address.
    assign imemload = 32'hA500_0000 ^ imemaddr;

    typedef struct {
        logic        ih, dq, rd, hl;
        logic [31:0] rpc;
        logic        e_ren, e_val, chk_addr;
        logic [31:0] e_addr, e_pc;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vt [21];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Head checks derived from expected valid/pc.
    task automatic chk_head(input string tag, input logic val, input logic [31:0] pc);
        chk({tag, " inst_valid"}, 32'(inst_valid), 32'(val));
        chk({tag, " inst_pc"},  inst_pc,  val ? pc : 32'h0);
        chk({tag, " inst_npc"}, inst_npc, val ? pc + 32'd4 : 32'h0);
        chk({tag, " inst"},     inst,     val ? (32'hA500_0000 ^ pc) : 32'h0);
    endtask

    function automatic vec_t mk(input logic ih, dq, rd, hl, input logic [31:0] rpc,
                                input logic e_ren, input logic [31:0] e_addr,
                                input logic chk_addr, input logic [2:0] e_cnt,
                                input logic e_val, input logic [31:0] e_pc);
        vec_t v;
        v.ih = ih; v.dq = dq; v.rd = rd; v.hl = hl; v.rpc = rpc;
        v.e_ren = e_ren; v.e_addr = e_addr; v.chk_addr = chk_addr;
        v.e_cnt = e_cnt; v.e_val = e_val; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //       ih dq rd hl rpc          ren addr         ca cnt val pc
        vt[0]  = mk(1, 0, 0, 0, 32'h0,      1, 32'h00,     1, 0, 0, 32'h00);
        vt[1]  = mk(1, 0, 0, 0, 32'h0,      1, 32'h04,     1, 1, 1, 32'h00);
        vt[2]  = mk(1, 0, 0, 0, 32'h0,      1, 32'h08,     1, 2, 1, 32'h00);
        vt[3]  = mk(1, 0, 0, 0, 32'h0,      1, 32'h0C,     1, 3, 1, 32'h00);
        vt[4]  = mk(1, 0, 0, 0, 32'h0,      0, 32'h10,     1, 4, 1, 32'h00);
        vt[5]  = mk(1, 0, 0, 0, 32'h0,      0, 32'h10,     1, 4, 1, 32'h00);
        vt[6]  = mk(1, 1, 0, 0, 32'h0,      1, 32'h10,     1, 3, 1, 32'h04);
        vt[7]  = mk(1, 0, 0, 0, 32'h0,      0, 32'h14,     1, 4, 1, 32'h04);
        vt[8]  = mk(1, 1, 0, 0, 32'h0,      1, 32'h14,     1, 3, 1, 32'h08);
        vt[9]  = mk(1, 1, 1, 0, 32'h43,     0, 32'h40,     1, 0, 0, 32'h00);
        vt[10] = mk(1, 0, 0, 0, 32'h0,      1, 32'h40,     1, 0, 0, 32'h00);
        vt[11] = mk(1, 1, 0, 0, 32'h0,      1, 32'h44,     1, 1, 1, 32'h40);
        vt[12] = mk(1, 1, 0, 0, 32'h0,      1, 32'h48,     1, 1, 1, 32'h44);
        vt[13] = mk(1, 1, 0, 0, 32'h0,      1, 32'h4C,     1, 1, 1, 32'h48);
        vt[14] = mk(1, 0, 1, 0, 32'h100,    0, 32'h100,    1, 0, 0, 32'h00);
        vt[15] = mk(1, 0, 1, 0, 32'h205,    0, 32'h204,    1, 0, 0, 32'h00);
        vt[16] = mk(1, 0, 0, 0, 32'h0,      1, 32'h204,    1, 0, 0, 32'h00);
        vt[17] = mk(1, 0, 0, 0, 32'h0,      1, 32'h208,    1, 1, 1, 32'h204);
        vt[18] = mk(1, 1, 1, 1, 32'h300,    0, 32'h0,      0, 0, 0, 32'h00);
        vt[19] = mk(1, 1, 1, 0, 32'h40,     0, 32'h0,      0, 0, 0, 32'h00);
        vt[20] = mk(1, 0, 0, 0, 32'h0,      0, 32'h0,      0, 0, 0, 32'h00);

        nRST = 1'b0; ihit = 1'b0; redirect = 1'b0; halt = 1'b0;
        deq_ready = 1'b0; redirect_pc = '0;
        #12;
        chk("reset imemREN",  32'(imemREN), 32'h0);
        chk("reset imemaddr", imemaddr, 32'h0);
        chk("reset count",    32'(count), 32'h0);
        chk_head("reset", 1'b0, 32'h0);

        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < 21; i++) begin
            ihit = vt[i].ih; deq_ready = vt[i].dq; redirect = vt[i].rd;
            halt = vt[i].hl; redirect_pc = vt[i].rpc;
            tick();
            chk($sformatf("v%0d imemREN", i), 32'(imemREN), 32'(vt[i].e_ren));
            if (vt[i].chk_addr)
                chk($sformatf("v%0d imemaddr", i), imemaddr, vt[i].e_addr);
            chk($sformatf("v%0d count", i), 32'(count), 32'(vt[i].e_cnt));
            chk_head($sformatf("v%0d", i), vt[i].e_val, vt[i].e_pc);
        end

        // Reset pulse leaves HALTED and restarts fetch at PC_INIT.
        ihit = 1'b0; deq_ready = 1'b0; redirect = 1'b0; halt = 1'b0;
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        chk("halt-rst imemaddr", imemaddr, 32'h0);
        chk("halt-rst imemREN",  32'(imemREN), 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        chk("post-rst imemREN",  32'(imemREN), 32'h1);
        chk("post-rst imemaddr", imemaddr, 32'h0);

        // Fetch PC wraps modulo 2^32.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        chk("wrap flush addr", imemaddr, 32'hFFFF_FFFC);
        chk("wrap flush ren",  32'(imemREN), 32'h0);
        redirect = 1'b0; ihit = 1'b1;
        tick();
        chk("wrap fetch ren", 32'(imemREN), 32'h1);
        tick();
        chk("wrap addr", imemaddr, 32'h0);
        chk("wrap count", 32'(count), 32'h1);
        chk_head("wrap", 1'b1, 32'hFFFF_FFFC);
        ihit = 1'b0; deq_ready = 1'b1;
        tick();
        chk("wrap drain count", 32'(count), 32'h0);

        // Asynchronous reset in the middle of a fill.
        deq_ready = 1'b0; ihit = 1'b1;
        tick(); tick(); tick();
        chk("prefill count", 32'(count), 32'h3);
        chk("prefill addr",  imemaddr, 32'hC);
        #2;
        nRST = 1'b0;
        #1;
        chk("async count",    32'(count), 32'h0);
        chk("async imemaddr", imemaddr, 32'h0);
        chk("async imemREN",  32'(imemREN), 32'h0);
        chk_head("async", 1'b0, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
